// File: rtl/param_serial_loader.sv
// rtl/param_serial_loader.sv - bit-serial to byte loader feeding the neuron parameter shift chain
module param_serial_loader #(
    parameter int unsigned NUM_PARAMS = 24,
    parameter logic [1:0]  SEL_SHIFT  = 2'b01,
    parameter logic [1:0]  SEL_HOLD   = 2'b10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       bit_in,
    input  logic       bit_valid,
    output logic [7:0] data_out,
    output logic [1:0] sel_out,
    output logic       busy,
    output logic       done,
    output logic       overrun,
    output logic [7:0] byte_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

    localparam logic [7:0] LAST_CNT = 8'(NUM_PARAMS);

    state_t     state_q, state_d;
    logic [7:0] sreg_q, sreg_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] data_q, data_d;
    logic [1:0] sel_q, sel_d;
    logic [7:0] byte_cnt_q, byte_cnt_d;
    logic       overrun_q, overrun_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            sreg_q     <= 8'd0;
            bit_cnt_q  <= 3'd0;
            data_q     <= 8'd0;
            sel_q      <= SEL_HOLD;
            byte_cnt_q <= 8'd0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sreg_q     <= sreg_d;
            bit_cnt_q  <= bit_cnt_d;
            data_q     <= data_d;
            sel_q      <= sel_d;
            byte_cnt_q <= byte_cnt_d;
            overrun_q  <= overrun_d;
        end
    end

    // sel defaults to HOLD every cycle so a SHIFT pulse can only ever last one cycle
    always_comb begin
        state_d    = state_q;
        sreg_d     = sreg_q;
        bit_cnt_d  = bit_cnt_q;
        data_d     = data_q;
        sel_d      = SEL_HOLD;
        byte_cnt_d = byte_cnt_q;
        overrun_d  = overrun_q;
        if (start) begin
            state_d    = S_LOAD;
            sreg_d     = 8'd0;
            bit_cnt_d  = 3'd0;
            byte_cnt_d = 8'd0;
            overrun_d  = 1'b0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    // Once the last byte is out, stop sampling so byte_cnt cannot pass NUM_PARAMS
                    if (byte_cnt_q == LAST_CNT) begin
                        state_d = S_DONE;
                    end else if (bit_valid) begin
                        sreg_d    = {sreg_q[6:0], bit_in};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            data_d     = {sreg_q[6:0], bit_in};
                            sel_d      = SEL_SHIFT;
                            byte_cnt_d = byte_cnt_q + 8'd1;
                        end
                    end
                end
                S_DONE: begin
                    if (bit_valid) begin
                        overrun_d = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign data_out = data_q;
    assign sel_out  = sel_q;
    assign busy     = (state_q == S_LOAD);
    assign done     = (state_q == S_DONE);
    assign overrun  = overrun_q;
    assign byte_cnt = byte_cnt_q;

endmodule

// File: tb/tb_param_serial_loader.sv
// tb/tb_param_serial_loader.sv - scoreboard testbench for param_serial_loader
module tb_param_serial_loader;

    localparam logic [1:0] SEL_SHIFT = 2'b01;
    localparam logic [1:0] SEL_HOLD  = 2'b10;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       bit_in = 1'b0;
    logic       bit_valid = 1'b0;
    logic [7:0] data_out;
    logic [1:0] sel_out;
    logic       busy;
    logic       done;
    logic       overrun;
    logic [7:0] byte_cnt;

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;
    int n_pulses = 0;
    logic [15:0] sb_q[$];
    int          pulse_cyc[$];

    param_serial_loader #(.NUM_PARAMS(24), .SEL_SHIFT(SEL_SHIFT), .SEL_HOLD(SEL_HOLD)) dut (
        .clk(clk), .reset(reset), .start(start), .bit_in(bit_in), .bit_valid(bit_valid),
        .data_out(data_out), .sel_out(sel_out), .busy(busy), .done(done),
        .overrun(overrun), .byte_cnt(byte_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every SHIFT pulse must match the oldest expected {byte_cnt, data}
    always @(negedge clk) begin
        if (sel_out == SEL_SHIFT) begin
            n_pulses++;
            pulse_cyc.push_back(cyc);
            if (sb_q.size() == 0) begin
                check("unexpected_shift", 32'(data_out), 32'hFFFF_FFFF);
            end else begin
                logic [15:0] e;
                e = sb_q.pop_front();
                check("shift_data", 32'(data_out), 32'(e[7:0]));
                check("shift_cnt", 32'(byte_cnt), 32'(e[15:8]));
            end
        end else if (sel_out != SEL_HOLD) begin
            check("sel_code", 32'(sel_out), 32'(SEL_HOLD));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        bit_valid = 1'b1;
        bit_in    = b;
        tick();
        bit_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic [7:0] exp_cnt, input bit gap);
        for (int i = 7; i >= 0; i--) begin
            if (i == 0) sb_q.push_back({exp_cnt, b});
            send_bit(b[i]);
            if (gap && i > 0) tick();
        end
    endtask

    initial begin
        logic [7:0] bv;
        #12;
        check("rst_data", 32'(data_out), 32'h0);
        check("rst_sel", 32'(sel_out), 32'(SEL_HOLD));
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);
        check("rst_cnt", 32'(byte_cnt), 32'h0);
        @(posedge clk);
        #1 reset = 1'b1;
        tick();

        // 1) async reset mid-stream
        do_start();
        check("t1_busy_pre", 32'(busy), 32'h1);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        reset = 1'b0;
        #2;
        check("t1_async_busy", 32'(busy), 32'h0);
        check("t1_async_cnt", 32'(byte_cnt), 32'h0);
        check("t1_async_sel", 32'(sel_out), 32'(SEL_HOLD));
        check("t1_async_data", 32'(data_out), 32'h0);
        @(posedge clk);
        #1 reset = 1'b1;
        tick();
        do_start();
        send_byte(8'hC3, 8'd1, 1'b0);

        // 2) single byte A5 on consecutive cycles
        do_start();
        check("t2_cnt_clr", 32'(byte_cnt), 32'h0);
        send_byte(8'hA5, 8'd1, 1'b0);
        check("t2_sel", 32'(sel_out), 32'(SEL_SHIFT));
        check("t2_data", 32'(data_out), 32'hA5);
        check("t2_cnt", 32'(byte_cnt), 32'h1);
        check("t2_busy", 32'(busy), 32'h1);
        tick();
        check("t2_sel_back", 32'(sel_out), 32'(SEL_HOLD));

        // 3) full gapped load 00..17
        do_start();
        for (int k = 0; k < 24; k++) begin
            bv = 8'(k);
            send_byte(bv, 8'(k + 1), 1'b1);
        end
        check("t3_cnt_last", 32'(byte_cnt), 32'd24);
        check("t3_done_early", 32'(done), 32'h0);
        tick();
        check("t3_done", 32'(done), 32'h1);
        check("t3_busy", 32'(busy), 32'h0);
        check("t3_cnt", 32'(byte_cnt), 32'd24);
        check("t3_data_hold", 32'(data_out), 32'h17);

        // 4) overrun in DONE
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        tick();
        check("t4_overrun", 32'(overrun), 32'h1);
        check("t4_cnt", 32'(byte_cnt), 32'd24);
        check("t4_done", 32'(done), 32'h1);
        do_start();
        check("t4_ovr_clr", 32'(overrun), 32'h0);
        check("t4_done_clr", 32'(done), 32'h0);
        check("t4_busy", 32'(busy), 32'h1);

        // 5) restart with simultaneous bit_valid after 3 bits of byte 4
        send_byte(8'h11, 8'd1, 1'b0);
        send_byte(8'h22, 8'd2, 1'b0);
        send_byte(8'h33, 8'd3, 1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        start = 1'b1;
        bit_valid = 1'b1;
        bit_in = 1'b1;
        tick();
        start = 1'b0;
        bit_valid = 1'b0;
        check("t5_cnt_clr", 32'(byte_cnt), 32'h0);
        check("t5_data_keep", 32'(data_out), 32'h33);
        check("t5_busy", 32'(busy), 32'h1);
        send_byte(8'h3C, 8'd1, 1'b0);
        check("t5_data", 32'(data_out), 32'h3C);

        // 6) continuous bits across byte boundaries
        do_start();
        pulse_cyc.delete();
        send_byte(8'h81, 8'd1, 1'b0);
        send_byte(8'h7E, 8'd2, 1'b0);
        send_byte(8'hC3, 8'd3, 1'b0);
        tick();
        check("t6_pulses", 32'(pulse_cyc.size()), 32'd3);
        if (pulse_cyc.size() == 3) begin
            check("t6_gap01", 32'(pulse_cyc[1] - pulse_cyc[0]), 32'd8);
            check("t6_gap12", 32'(pulse_cyc[2] - pulse_cyc[1]), 32'd8);
        end

        tick();
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        check("total_pulses", 32'(n_pulses), 32'd33);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
